// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI command sequencer.
// Opcodes, FSM state encoding and one-hot command bundle.
package spi_pkg;

    localparam int RX_WORD_W = 10;
    localparam int PAYLOAD_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_TX      = 3'd4
    } state_t;

    typedef struct packed {
        logic wr_addr;
        logic wr_data;
        logic rd_addr;
        logic rd_data;
    } cmd_t;

endpackage

// File: rtl/spi_cmd_decode.sv
// Rising-edge detect on rx_valid and opcode/payload split.
// Ports: clk, rst_n, rx_data, rx_valid in; cmd (one-hot pulses), cmd_evt, payload out.
module spi_cmd_decode
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RX_WORD_W-1:0] rx_data,
    input  logic                 rx_valid,
    output cmd_t                 cmd,
    output logic                 cmd_evt,
    output logic [PAYLOAD_W-1:0] payload
);

    logic rx_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
        end
    end

    // A level held high is a single event.
    assign cmd_evt = rx_valid & ~rx_valid_q;
    assign payload = rx_data[PAYLOAD_W-1:0];

    always_comb begin
        cmd = '0;
        if (cmd_evt) begin
            unique case (rx_data[RX_WORD_W-1:PAYLOAD_W])
                OP_WR_ADDR: cmd.wr_addr = 1'b1;
                OP_WR_DATA: cmd.wr_data = 1'b1;
                OP_RD_ADDR: cmd.rd_addr = 1'b1;
                OP_RD_DATA: cmd.rd_data = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command sequencer between SPI slave rx/tx and a request/ready memory port.
// Ports: rx_data/rx_valid/ss_n from slave; tx_data/tx_valid to slave; mem_* port; busy, cmd_drop.
module spi_mem_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RX_WORD_W-1:0]  rx_data,
    input  logic                  rx_valid,
    input  logic                  ss_n,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy,
    output logic                  cmd_drop
);

    cmd_t                  cmd;
    logic                  cmd_evt;
    logic [PAYLOAD_W-1:0]  payload;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_done;
    logic                  rd_done;
    logic                  idle;

    spi_cmd_decode u_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd      (cmd),
        .cmd_evt  (cmd_evt),
        .payload  (payload)
    );

    assign idle = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd.wr_data) begin
                    state_nxt = ST_WR_REQ;
                end else if (cmd.rd_data) begin
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wr_addr;
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                    wr_done   = 1'b1;
                end
            end
            ST_RD_REQ: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
                if (mem_ready) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Keep waiting even if the master already dropped ss_n.
                if (mem_rvalid) begin
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                tx_valid = 1'b1;
                if (ss_n) begin
                    state_nxt = ST_IDLE;
                    rd_done   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wdata_q  <= '0;
            tx_data  <= '0;
            cmd_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_drop <= cmd_evt & ~idle;

            if (idle && cmd.wr_addr) begin
                wr_addr <= payload[ADDR_WIDTH-1:0];
            end else if (wr_done && AUTO_INC != 0) begin
                wr_addr <= wr_addr + 1'b1;
            end

            if (idle && cmd.rd_addr) begin
                rd_addr <= payload[ADDR_WIDTH-1:0];
            end else if (rd_done && AUTO_INC != 0) begin
                rd_addr <= rd_addr + 1'b1;
            end

            if (idle && cmd.wr_data) begin
                wdata_q <= payload;
            end

            if (state == ST_RD_WAIT && mem_rvalid) begin
                tx_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl, AUTO_INC=0 and AUTO_INC=1 in lockstep.
// Ports: drives shared stimulus into both instances, models memory responses.
module tb_spi_mem_ctrl;

    logic       clk = 0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       ss_n;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;

    logic [7:0] tx_data0, tx_data1, addr0, addr1, wdata0, wdata1;
    logic       tx_valid0, tx_valid1, en0, en1, we0, we1;
    logic       busy0, busy1, drop0, drop1;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ss_n(ss_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .mem_en(en0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy0), .cmd_drop(drop0)
    );

    spi_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ss_n(ss_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy1), .cmd_drop(drop1)
    );

    typedef struct {
        bit         we;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] d;
    } req_t;

    req_t       req_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_mem[256];
    logic [7:0] mem_model[256];
    logic [7:0] wa0, ra0, wa1, ra1;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0, en_cnt = 0, drop_cnt = 0, accepts = 0;
    int stab_err = 0, tx_rise = 0, lockstep_err = 0;
    int rd_lat = 1, rd_cnt = 0;
    logic [7:0] rd_a = 0, last_a1 = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one command word; model updates only for accepted commands.
    task automatic send(input logic [1:0] op, input logic [7:0] p,
                        input int hold, input bit acc);
        rx_data  = {op, p};
        rx_valid = 1'b1;
        if (acc) begin
            case (op)
                2'b00: begin wa0 = p; wa1 = p; end
                2'b10: begin ra0 = p; ra1 = p; end
                2'b01: begin
                    req_q.push_back('{we: 1'b1, a0: wa0, a1: wa1, d: p});
                    exp_mem[wa0] = p;
                    wa1 = wa1 + 8'd1;
                end
                default: begin
                    req_q.push_back('{we: 1'b0, a0: ra0, a1: ra1, d: 8'h00});
                    tx_q.push_back(exp_mem[ra0]);
                    ra1 = ra1 + 8'd1;
                end
            endcase
        end
        tick(hold);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid0 && n < 50);
        if (!tx_valid0) check("tx_timeout", 0, 1);
    endtask

    task automatic end_tx(input string tag);
        @(posedge clk); #1;
        ss_n = 1'b1;
        @(posedge clk); #1;
        ss_n = 1'b0;
        @(negedge clk);
        check({tag, "_txv_off"}, tx_valid0, 0);
        check({tag, "_busy_off"}, busy0, 0);
        @(posedge clk); #1;
    endtask

    // Monitor and scoreboard.
    initial begin
        logic       en_prev = 0, tx_prev = 0;
        logic [16:0] prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 0;
                tx_prev = 0;
            end else begin
                if ({en1, we1, busy1, drop1, tx_valid1} !==
                    {en0, we0, busy0, drop0, tx_valid0})
                    lockstep_err++;
                if (busy0) busy_cnt++;
                if (drop0) drop_cnt++;
                if (en0) begin
                    en_cnt++;
                    if (en_prev && prev !== {we0, addr0, wdata0}) stab_err++;
                end
                en_prev = en0;
                prev    = {we0, addr0, wdata0};
                if (en0 && mem_ready) begin
                    accepts++;
                    if (req_q.size() == 0) begin
                        check("req_unexpected", 1, 0);
                    end else begin
                        req_t r;
                        r = req_q.pop_front();
                        check("req_we", we0, r.we);
                        check("req_addr0", addr0, r.a0);
                        check("req_addr1", addr1, r.a1);
                        last_a1 = addr1;
                        if (r.we) begin
                            check("req_wdata0", wdata0, r.d);
                            check("req_wdata1", wdata1, r.d);
                            mem_model[addr0] = wdata0;
                        end else begin
                            rd_a   = addr0;
                            rd_cnt = rd_lat;
                        end
                    end
                end
                if (tx_valid0 && !tx_prev) begin
                    tx_rise++;
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected", 1, 0);
                    end else begin
                        logic [7:0] e;
                        e = tx_q.pop_front();
                        check("tx_data0", tx_data0, e);
                        check("tx_data1", tx_data1, e);
                    end
                end
                tx_prev = tx_valid0;
            end
        end
    end

    // Memory read responder: rvalid rd_lat cycles after acceptance.
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_model[rd_a];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0, d0, a0c, t0;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i]   = 8'h00;
            mem_model[i] = 8'h00;
        end
        wa0 = 0; ra0 = 0; wa1 = 0; ra1 = 0;
        rst_n = 0; rx_data = 0; rx_valid = 0; ss_n = 0;
        mem_ready = 1; mem_rdata = 0; mem_rvalid = 0;

        repeat (3) @(negedge clk);
        check("rst_mem_en", en0, 0);
        check("rst_mem_we", we0, 0);
        check("rst_mem_addr", addr0, 0);
        check("rst_mem_wdata", wdata0, 0);
        check("rst_tx", {tx_valid0, tx_data0}, 0);
        check("rst_busy_drop", {busy0, drop0}, 0);
        tick(1);
        rst_n = 1;
        tick(1);

        // Address latch then single-cycle write.
        send(2'b00, 8'h2A, 1, 1);
        tick(1);
        busy_cnt = 0; en_cnt = 0;
        send(2'b01, 8'h5C, 1, 1);
        tick(3);
        check("wr_busy_cycles", busy_cnt, 1);
        check("wr_en_cycles", en_cnt, 1);
        check("wr_idle_we_addr", {we0, addr0}, 0);
        check("wr_wdata_hold", wdata0, 8'h5C);

        // Read back with 2-cycle memory latency, held until ss_n.
        rd_lat = 2;
        send(2'b10, 8'h2A, 1, 1);
        tick(1);
        send(2'b11, 8'h00, 1, 1);
        wait_tx(n);
        repeat (2) @(negedge clk);
        check("rd_tx_hold", tx_valid0, 1);
        check("rd_tx_value", tx_data0, 8'h5C);
        end_tx("rd");

        // Minimum latency with ready=1 and 1-cycle rvalid.
        rd_lat = 1;
        send(2'b11, 8'h00, 1, 1);
        wait_tx(n);
        check("rd_min_latency", n, 3);
        end_tx("lat");

        // Write stalled 5 cycles by mem_ready.
        mem_ready = 0;
        en_cnt = 0; stab_err = 0; a0c = accepts;
        send(2'b01, 8'h77, 1, 1);
        repeat (5) @(posedge clk);
        #1 mem_ready = 1;
        tick(3);
        check("stall_en_cycles", en_cnt, 6);
        check("stall_stable", stab_err, 0);
        check("stall_accepts", accepts - a0c, 1);

        // Command arriving during a pending read is dropped.
        mem_ready = 0;
        send(2'b11, 8'h00, 1, 1);
        tick(1);
        d0 = drop_cnt;
        send(2'b00, 8'h11, 1, 0);
        tick(2);
        check("drop_pulse", drop_cnt - d0, 1);
        check("drop_still_busy", busy0, 1);
        mem_ready = 1;
        wait_tx(n);
        check("drop_rd_value", tx_data0, 8'h77);
        end_tx("drop");
        send(2'b01, 8'h44, 1, 1);
        tick(2);
        check("drop_waddr_kept", last_a1 == wa1 - 8'd1, 1);

        // Auto-increment wrap on the AUTO_INC=1 instance.
        send(2'b00, 8'hFF, 1, 1);
        tick(1);
        send(2'b01, 8'h01, 1, 1);
        tick(2);
        check("inc_addr_first", last_a1, 8'hFF);
        send(2'b01, 8'h02, 1, 1);
        tick(2);
        check("inc_addr_wrap", last_a1, 8'h00);

        // Held rx_valid is one event.
        a0c = accepts; d0 = drop_cnt;
        send(2'b01, 8'h99, 3, 1);
        tick(2);
        check("held_single_write", accepts - a0c, 1);
        check("held_no_drop", drop_cnt - d0, 0);

        // Reset during RD_WAIT abandons the read.
        rd_lat = 6;
        send(2'b11, 8'h00, 1, 1);
        tick(1);
        check("rst_pre_wait", {busy0, en0}, 2'b10);
        #1 rst_n = 0;
        #1;
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_outs", {en0, we0, addr0, tx_valid0, drop0}, 0);
        tick(1);
        rst_n = 1;
        tx_q.delete();
        wa0 = 0; ra0 = 0; wa1 = 0; ra1 = 0;
        busy_cnt = 0; t0 = tx_rise;
        tick(10);
        check("rst_rvalid_ignored", tx_rise - t0, 0);
        check("rst_idle_busy", busy_cnt, 0);

        // Addresses restart at zero after reset.
        rd_lat = 1;
        send(2'b01, 8'h3C, 1, 1);
        tick(2);
        send(2'b11, 8'h00, 1, 1);
        wait_tx(n);
        check("post_rst_read", tx_data0, 8'h3C);
        end_tx("post");

        tick(2);
        check("req_q_empty", req_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        check("lockstep", lockstep_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
